// File: rtl/mips_harvard_mem.sv
// Unified instruction/data word memory with a combinational dual read port, a CPU store port,
// and a byte-stream loader that assembles little-endian words behind CPU writes.
module mips_harvard_mem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LOAD_BASE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        access_err,
    output logic [15:0] read_count,
    output logic [15:0] write_count
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LANE_W  = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        COMMIT   = 2'd2
    } load_state_t;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] instr_idx;
    logic [DEPTH_LOG2-1:0] data_idx;
    logic                  misaligned;
    logic                  access_bad;
    logic                  cpu_we;
    logic                  read_ok;
    logic                  unused_addr_bits;

    load_state_t           state;
    load_state_t           state_n;
    logic [LANE_W-1:0]     lane;
    logic [LANE_W-1:0]     lane_n;
    logic [31:0]           word;
    logic [31:0]           word_n;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2-1:0] ptr_n;
    logic                  commit_we;

    assign instr_idx = instr_address[DEPTH_LOG2+1:2];
    assign data_idx  = data_address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{instr_address[31:DEPTH_LOG2+2], instr_address[1:0],
                                data_address[31:DEPTH_LOG2+2]};

    // Reads see the array before any write on this edge, so read-during-write returns old data.
    assign instr_readdata = mem[instr_idx];
    assign data_readdata  = data_read ? mem[data_idx] : 32'h0;

    assign misaligned = (data_address[1:0] != 2'b00);
    assign access_bad = (misaligned && (data_read || data_write)) || (data_read && data_write);
    assign cpu_we     = data_write && !access_bad;
    assign read_ok    = data_read && !access_bad;

    // Loader next-state: load_start dominates; a CPU write stalls the commit.
    always_comb begin
        state_n   = state;
        lane_n    = lane;
        word_n    = word;
        ptr_n     = ptr;
        commit_we = 1'b0;
        if (load_start) begin
            state_n = IDLE;
            lane_n  = '0;
            word_n  = '0;
            ptr_n   = DEPTH_LOG2'(LOAD_BASE);
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        word_n  = {24'h0, load_byte};
                        lane_n  = LANE_W'(1);
                        state_n = ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (load_valid) begin
                        word_n[{lane, 3'b000} +: 8] = load_byte;
                        lane_n = lane + LANE_W'(1);
                        if (lane == LANE_W'(3)) begin
                            state_n = COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (!data_write) begin
                        commit_we = 1'b1;
                        ptr_n     = ptr + DEPTH_LOG2'(1);
                        lane_n    = '0;
                        word_n    = '0;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Single write port: CPU and loader commit never coincide because commit waits on data_write.
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[data_idx] <= data_writedata;
        end else if (commit_we && !reset) begin
            mem[ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lane        <= '0;
            word        <= '0;
            ptr         <= DEPTH_LOG2'(LOAD_BASE);
            load_ready  <= 1'b1;
            access_err  <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            word       <= word_n;
            ptr        <= ptr_n;
            load_ready <= (state_n != COMMIT);
            if (access_bad) begin
                access_err <= 1'b1;
            end
            if (read_ok && (read_count != 16'hFFFF)) begin
                read_count <= read_count + CNT_W'(1);
            end
            if (cpu_we && (write_count != 16'hFFFF)) begin
                write_count <= write_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: directed scenarios plus randomized traffic
// compared against a word-array / byte-queue reference model.
module tb_mips_harvard_mem;

    localparam int unsigned DL    = 10;
    localparam int unsigned DEPTH = 1 << DL;
    localparam int unsigned LB    = 0;

    logic        clk;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        access_err;
    logic [15:0] read_count;
    logic [15:0] write_count;

    mips_harvard_mem #(.DEPTH_LOG2(DL), .LOAD_BASE(LB)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_byte      (load_byte),
        .load_ready     (load_ready),
        .access_err     (access_err),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model state
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_err;
    int          m_rc;
    int          m_wc;
    int          m_ptr;
    bit          m_pend;
    logic [31:0] m_word;
    logic [7:0]  m_bytes [$];

    task automatic model_update();
        int  di;
        bit  bad;
        di  = int'(data_address[DL+1:2]);
        bad = ((data_address[1:0] != 2'b00) && (data_read || data_write)) || (data_read && data_write);
        if (data_write && !bad) begin
            m_mem[di]   = data_writedata;
            m_known[di] = 1'b1;
        end
        if (reset) begin
            m_err  = 1'b0;
            m_rc   = 0;
            m_wc   = 0;
            m_ptr  = LB;
            m_pend = 1'b0;
            m_bytes.delete();
        end else begin
            if (bad) m_err = 1'b1;
            if (data_read && !bad && m_rc < 65535) m_rc++;
            if (data_write && !bad && m_wc < 65535) m_wc++;
            if (load_start) begin
                m_ptr  = LB;
                m_pend = 1'b0;
                m_bytes.delete();
            end else if (m_pend) begin
                if (!data_write) begin
                    m_mem[m_ptr]   = m_word;
                    m_known[m_ptr] = 1'b1;
                    m_ptr  = (m_ptr + 1) % DEPTH;
                    m_pend = 1'b0;
                end
            end else if (load_valid) begin
                m_bytes.push_back(load_byte);
                if (m_bytes.size() == 4) begin
                    m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_bytes.delete();
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_address   = 32'h0;
        data_writedata = 32'h0;
        load_start     = 1'b0;
        load_valid     = 1'b0;
        load_byte      = 8'h0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard      = 0;
        load_valid = 1'b1;
        load_byte  = b;
        #1;
        while (!load_ready && guard < 8) begin
            step();
            #1;
            guard++;
        end
        if (guard >= 8) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte_timeout: load_ready stayed %0b, expected 1", load_ready);
        end
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        instr_address = 32'h0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_chk++; if (access_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", access_err); end
        n_chk++; if (read_count !== 16'h0) begin n_fail++; $display("FAIL reset_rc: got %h expected 0000", read_count); end
        n_chk++; if (write_count !== 16'h0) begin n_fail++; $display("FAIL reset_wc: got %h expected 0000", write_count); end
        n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", load_ready); end
    endtask

    task automatic test_loader();
        logic [7:0] seq [8];
        seq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        foreach (seq[i]) send_byte(seq[i]);
        step();
        instr_address = 32'h0;
        #1;
        n_chk++; if (instr_readdata !== 32'h12345678) begin n_fail++; $display("FAIL loader_w0: got %h expected 12345678", instr_readdata); end
        instr_address = 32'h4;
        #1;
        n_chk++; if (instr_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL loader_w1: got %h expected deadbeef", instr_readdata); end
        n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL loader_ready: got %0b expected 1", load_ready); end
    endtask

    task automatic test_store_load();
        idle_inputs();
        data_write = 1'b1; data_address = 32'h10; data_writedata = 32'h11111111;
        step();
        do_reset();
        instr_address  = 32'h10;
        data_write     = 1'b1;
        data_address   = 32'h10;
        data_writedata = 32'hCAFEF00D;
        #1;
        n_chk++; if (instr_readdata !== 32'h11111111) begin n_fail++; $display("FAIL rdw_old: got %h expected 11111111", instr_readdata); end
        n_chk++; if (data_readdata !== 32'h0) begin n_fail++; $display("FAIL rd_idle_zero: got %h expected 00000000", data_readdata); end
        step();
        data_write = 1'b0;
        data_read  = 1'b1;
        #1;
        n_chk++; if (data_readdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_new: got %h expected cafef00d", data_readdata); end
        n_chk++; if (instr_readdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_new_instr: got %h expected cafef00d", instr_readdata); end
        n_chk++; if (write_count !== 16'd1) begin n_fail++; $display("FAIL store_wc: got %0d expected 1", write_count); end
        step();
        data_read = 1'b0;
        #1;
        n_chk++; if (read_count !== 16'd1) begin n_fail++; $display("FAIL store_rc: got %0d expected 1", read_count); end
    endtask

    task automatic test_misaligned();
        idle_inputs();
        instr_address  = 32'h10;
        data_write     = 1'b1;
        data_address   = 32'h12;
        data_writedata = 32'hBAD0BAD0;
        step();
        data_write = 1'b0;
        #1;
        n_chk++; if (instr_readdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mis_nowrite: got %h expected cafef00d", instr_readdata); end
        n_chk++; if (access_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %0b expected 1", access_err); end
        n_chk++; if (write_count !== 16'd1) begin n_fail++; $display("FAIL mis_wc: got %0d expected 1", write_count); end
        data_write = 1'b1; data_address = 32'h20; data_writedata = 32'h00C0FFEE;
        step();
        data_write = 1'b0; data_read = 1'b1;
        #1;
        n_chk++; if (data_readdata !== 32'h00C0FFEE) begin n_fail++; $display("FAIL mis_good: got %h expected 00c0ffee", data_readdata); end
        step();
        data_read = 1'b0;
        #1;
        n_chk++; if (access_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %0b expected 1", access_err); end
        // Simultaneous read and write is also an error and suppresses the write
        do_reset();
        data_read = 1'b1; data_write = 1'b1; data_address = 32'h20; data_writedata = 32'h0;
        #1;
        n_chk++; if (data_readdata !== 32'h00C0FFEE) begin n_fail++; $display("FAIL rw_read: got %h expected 00c0ffee", data_readdata); end
        step();
        data_write = 1'b0;
        #1;
        n_chk++; if (data_readdata !== 32'h00C0FFEE) begin n_fail++; $display("FAIL rw_nowrite: got %h expected 00c0ffee", data_readdata); end
        n_chk++; if (access_err !== 1'b1 || read_count !== 16'd0) begin n_fail++; $display("FAIL rw_err: got err=%0b rc=%0d expected err=1 rc=0", access_err, read_count); end
        do_reset();
        #1;
        n_chk++; if (access_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %0b expected 0", access_err); end
    endtask

    task automatic test_contention();
        do_reset();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        data_write = 1'b1; data_address = 32'h40; data_writedata = 32'h600DF00D;
        instr_address = 32'h0;
        #1;
        n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready0: got %0b expected 0", load_ready); end
        step();
        data_write = 1'b0; data_read = 1'b1;
        #1;
        n_chk++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready1: got %0b expected 0", load_ready); end
        n_chk++; if (data_readdata !== 32'h600DF00D) begin n_fail++; $display("FAIL cont_cpu: got %h expected 600df00d", data_readdata); end
        n_chk++; if (instr_readdata !== 32'h12345678) begin n_fail++; $display("FAIL cont_deferred: got %h expected 12345678", instr_readdata); end
        step();
        data_read = 1'b0;
        #1;
        n_chk++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready2: got %0b expected 1", load_ready); end
        n_chk++; if (instr_readdata !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL cont_loader: got %h expected ddccbbaa", instr_readdata); end
    endtask

    task automatic test_load_start();
        logic [31:0] a;
        idle_inputs();
        send_byte(8'hAA); send_byte(8'hBB);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h99;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        step();
        a = 32'(LB * 4);
        instr_address = a;
        #1;
        n_chk++; if (instr_readdata !== 32'h04030201) begin n_fail++; $display("FAIL load_start_word: got %h expected 04030201", instr_readdata); end
    endtask

    task automatic test_random();
        int unsigned r;
        int iidx;
        int didx;
        logic [31:0] exp_d;
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            r = $urandom_range(0, 99);
            reset = (r < 1);
            instr_address = $urandom;
            instr_address[DL+1:2] = DL'($urandom_range(0, 15));
            data_address = $urandom;
            data_address[DL+1:2] = DL'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0) data_address[1:0] = 2'b00;
            r = $urandom_range(0, 99);
            data_read      = (r < 40) || (r >= 95);
            data_write     = (r >= 40 && r < 70) || (r >= 95);
            data_writedata = $urandom;
            load_valid     = ($urandom_range(0, 1) == 1);
            load_byte      = 8'($urandom);
            load_start     = ($urandom_range(0, 49) == 0);
            #1;
            iidx = int'(instr_address[DL+1:2]);
            didx = int'(data_address[DL+1:2]);
            if (m_known[iidx]) begin
                n_chk++;
                if (instr_readdata !== m_mem[iidx]) begin n_fail++; $display("FAIL rnd_instr c=%0d: got %h expected %h", c, instr_readdata, m_mem[iidx]); end
            end
            if (!data_read || m_known[didx]) begin
                exp_d = data_read ? m_mem[didx] : 32'h0;
                n_chk++;
                if (data_readdata !== exp_d) begin n_fail++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, data_readdata, exp_d); end
            end
            n_chk++; if (load_ready !== !m_pend) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %0b expected %0b", c, load_ready, !m_pend); end
            n_chk++; if (access_err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d: got %0b expected %0b", c, access_err, m_err); end
            n_chk++; if (read_count !== 16'(m_rc)) begin n_fail++; $display("FAIL rnd_rc c=%0d: got %0d expected %0d", c, read_count, m_rc); end
            n_chk++; if (write_count !== 16'(m_wc)) begin n_fail++; $display("FAIL rnd_wc c=%0d: got %0d expected %0d", c, write_count, m_wc); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        data_read    = 1'b1;
        data_address = 32'h10;
        for (int i = 0; i < 65540; i++) step();
        data_read = 1'b0;
        #1;
        n_chk++; if (read_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_rc: got %h expected ffff", read_count); end
        n_chk++; if (read_count !== 16'(m_rc)) begin n_fail++; $display("FAIL sat_model: got %h expected %h", read_count, 16'(m_rc)); end
        n_chk++; if (write_count !== 16'h0 || access_err !== 1'b0) begin n_fail++; $display("FAIL sat_side: got wc=%h err=%0b expected 0000 0", write_count, access_err); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        instr_address = 32'h0;
        test_reset();
        test_loader();
        test_store_load();
        test_misaligned();
        test_contention();
        test_load_start();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
